// File: rtl/decoder_nto2n_pipe.sv
// Registered N-to-2^N decoder with valid/ready handshake, one-hot/thermometer/sticky modes,
// decode enable and selectable output polarity. Single output register, latency 1.
module decoder_nto2n_pipe #(
    parameter int IN_W       = 2,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_sel,
    input  logic                   in_en,
    input  logic [1:0]             in_mode,
    input  logic                   clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(1<<IN_W)-1:0]   out_data,
    output logic                   out_err
);

    localparam int OUT_W = 1 << IN_W;
    localparam logic [OUT_W-1:0] IDLE = {OUT_W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'b00,
        MODE_THERMO  = 2'b01,
        MODE_STICKY  = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] sel);
        return OUT_W'(1) << sel;
    endfunction

    function automatic logic [OUT_W-1:0] thermo(input logic [IN_W-1:0] sel);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_W; i++) begin
            v[i] = (i[IN_W-1:0] <= sel);
        end
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] to_pin(input logic [OUT_W-1:0] v);
        return ACTIVE_LOW ? ~v : v;
    endfunction

    logic             vld_p1_q,  vld_p1_d;
    logic [OUT_W-1:0] data_p1_q, data_p1_d;
    logic             err_p1_q,  err_p1_d;
    logic [OUT_W-1:0] acc_q,     acc_d;

    logic             accept_p0;
    logic [OUT_W-1:0] vec_p0;
    logic             err_p0;
    logic [OUT_W-1:0] acc_base_p0;
    mode_e            mode_p0;

    assign in_ready  = !vld_p1_q || out_ready;
    assign accept_p0 = in_valid && in_ready;
    assign mode_p0   = mode_e'(in_mode);

    // Stage p0: decode and accumulator update; clr zeroes acc before any sticky OR.
    always_comb begin
        acc_base_p0 = clr ? '0 : acc_q;
        vec_p0      = '0;
        err_p0      = 1'b0;
        acc_d       = acc_base_p0;
        if (in_en) begin
            case (mode_p0)
                MODE_ONEHOT: vec_p0 = onehot(in_sel);
                MODE_THERMO: vec_p0 = thermo(in_sel);
                MODE_STICKY: begin
                    vec_p0 = acc_base_p0 | onehot(in_sel);
                    if (accept_p0) begin
                        acc_d = vec_p0;
                    end
                end
                default:     err_p0 = 1'b1;
            endcase
        end
    end

    // Stage p1: output register, holds while stalled.
    always_comb begin
        vld_p1_d  = vld_p1_q;
        data_p1_d = data_p1_q;
        err_p1_d  = err_p1_q;
        if (accept_p0) begin
            vld_p1_d  = 1'b1;
            data_p1_d = to_pin(vec_p0);
            err_p1_d  = err_p0;
        end else if (vld_p1_q && out_ready) begin
            vld_p1_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            data_p1_q <= IDLE;
            err_p1_q  <= 1'b0;
            acc_q     <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            data_p1_q <= data_p1_d;
            err_p1_q  <= err_p1_d;
            acc_q     <= acc_d;
        end
    end

    assign out_valid = vld_p1_q;
    assign out_data  = data_p1_q;
    assign out_err   = err_p1_q;

endmodule
